mmio_arb: RTL and testbench

Two-master arbiter that shares the single-ported data memory / memory-mapped I/O block between the core's data port (master 0) and a second requester such as a loader or DMA engine (master 1). It issues at most one memory access per cycle, grants round-robin on contention, supports short locked bursts with a bounded hold, and returns registered read data one cycle after the access.

---
 rtl/mmio_arb_pkg.sv | 23 ++
 rtl/mmio_arb_pick.sv | 25 ++
 rtl/mmio_arb.sv | 151 +++++++++++++++
 tb/tb_mmio_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared types and defaults for the two-master memory/MMIO arbiter.
package mmio_arb_pkg;

  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefMaxHold = 8;
  localparam int unsigned HoldW      = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  typedef logic [0:0] mst_idx_t;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [HoldW-1:0] sat_inc(input logic [HoldW-1:0] val,
                                               input logic [HoldW-1:0] ceil);
    return (val >= ceil) ? ceil : val + HoldW'(1);
  endfunction

endpackage

// File: rtl/mmio_arb_pick.sv
// Combinational two-way round-robin picker: on a tie the master that was not granted last wins.
module rr_pick2
  import mmio_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_idx_t   last_i,
  output logic [1:0] gnt_o,
  output mst_idx_t   idx_o
);

  always_comb begin
    gnt_o = 2'b00;
    idx_o = 1'b0;
    unique case (req_i)
      2'b01: idx_o = 1'b0;
      2'b10: idx_o = 1'b1;
      2'b11: idx_o = ~last_i;
      default: idx_o = 1'b0;
    endcase
    if (req_i != 2'b00) begin
      gnt_o = 2'b01 << idx_o;
    end
  end

endmodule

// File: rtl/mmio_arb.sv
// Two-master arbiter for the single-ported data memory / MMIO block with round-robin on
// contention, bounded locked bursts and one-cycle registered read return.
module mmio_arb
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned MAX_HOLD = DefMaxHold
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [HoldW-1:0] MaxHold = HoldW'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  mst_idx_t         last_q, last_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [1:0]       rvalid_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0] req, lock, we;
  logic [1:0] pick_gnt;
  mst_idx_t   pick_idx;
  logic [1:0] gnt_vec;
  mst_idx_t   gnt_idx;
  mst_idx_t   own_idx;
  logic       use_pick;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};
  assign we   = {m1_we, m0_we};
  assign own_idx = mst_idx_t'(state_q == StOwn1);

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = hold_q;
    gnt_vec  = 2'b00;
    gnt_idx  = 1'b0;
    use_pick = 1'b0;

    unique case (state_q)
      StIdle: use_pick = 1'b1;
      StOwn0, StOwn1: begin
        // Forced rotation beats both continuation and release of the lock.
        if (req[own_idx] && !((hold_q >= MaxHold) && req[~own_idx])) begin
          gnt_vec[own_idx] = 1'b1;
          gnt_idx          = own_idx;
          if (lock[own_idx]) begin
            hold_d = sat_inc(hold_q, MaxHold);
          end else begin
            state_d = StIdle;
            hold_d  = '0;
          end
        end else begin
          // Owner is last, so a tie in the picker hands over to the other master.
          use_pick = 1'b1;
        end
      end
      default: use_pick = 1'b1;
    endcase

    if (use_pick) begin
      state_d = StIdle;
      hold_d  = '0;
      if (pick_gnt != 2'b00) begin
        gnt_vec = pick_gnt;
        gnt_idx = pick_idx;
        if (lock[pick_idx]) begin
          state_d = pick_idx ? StOwn1 : StOwn0;
          hold_d  = HoldW'(1);
        end
      end
    end

    if (gnt_vec != 2'b00) begin
      last_d = gnt_idx;
    end
  end

  always_comb begin
    mem_memwrite  = 1'b0;
    mem_memread   = 1'b0;
    mem_addr      = '0;
    mem_writedata = '0;
    if (gnt_vec != 2'b00) begin
      mem_memwrite  = we[gnt_idx];
      mem_memread   = ~we[gnt_idx];
      mem_addr      = gnt_idx ? m1_addr : m0_addr;
      mem_writedata = gnt_idx ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      hold_q   <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      rvalid_q <= gnt_vec & ~we;
      if (gnt_vec[0] && !m0_we) rdata0_q <= mem_readdata;
      if (gnt_vec[1] && !m1_we) rdata1_q <= mem_readdata;
    end
  end

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mmio_arb.sv
// Self-checking bench for mmio_arb: directed scenarios plus randomized traffic against a
// rule-level arbitration model and a behavioural memory.
module tb_mmio_arb;

  localparam int unsigned MAXH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_memwrite, mem_memread;
  logic [31:0] mem_addr, mem_writedata, mem_readdata;

  bit          req_v[2], we_v[2], lock_v[2];
  logic [31:0] addr_v[2], wdata_v[2];

  logic [31:0] bmem [0:4095];

  int errors = 0;
  int checks = 0;

  // Rule-level model state
  int          mdl_owner, mdl_last, mdl_hold;
  bit   [1:0]  mdl_rv;
  logic [31:0] mdl_rd[2];

  int          exp_g;
  logic [1:0]  exp_gv;
  logic        exp_mw, exp_mr;
  logic [31:0] exp_addr, exp_wd;

  always #5 clk = ~clk;

  assign mem_readdata = bmem[mem_addr[11:0]];
  always @(posedge clk) if (mem_memwrite) bmem[mem_addr[11:0]] <= mem_writedata;

  mmio_arb #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_req        (req_v[0]),
    .m0_we         (we_v[0]),
    .m0_addr       (addr_v[0]),
    .m0_wdata      (wdata_v[0]),
    .m0_lock       (lock_v[0]),
    .m0_gnt        (m0_gnt),
    .m0_rvalid     (m0_rvalid),
    .m0_rdata      (m0_rdata),
    .m1_req        (req_v[1]),
    .m1_we         (we_v[1]),
    .m1_addr       (addr_v[1]),
    .m1_wdata      (wdata_v[1]),
    .m1_lock       (lock_v[1]),
    .m1_gnt        (m1_gnt),
    .m1_rvalid     (m1_rvalid),
    .m1_rdata      (m1_rdata),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  function automatic int model_pick();
    if (mdl_owner >= 0) begin
      if (req_v[mdl_owner] && !(mdl_hold >= int'(MAXH) && req_v[1 - mdl_owner]))
        return mdl_owner;
    end
    if (req_v[0] && req_v[1]) return 1 - mdl_last;
    if (req_v[0]) return 0;
    if (req_v[1]) return 1;
    return -1;
  endfunction

  task automatic set_m(input int i, input bit rq, input bit w, input logic [31:0] ad,
                       input logic [31:0] wd, input bit lk);
    req_v[i] = rq; we_v[i] = w; addr_v[i] = ad; wdata_v[i] = wd; lock_v[i] = lk;
  endtask

  // Move to the sampling point of the current cycle and form the expected bus picture.
  task automatic settle();
    @(negedge clk);
    exp_g    = model_pick();
    exp_gv   = 2'b00;
    exp_mw   = 1'b0;
    exp_mr   = 1'b0;
    exp_addr = '0;
    exp_wd   = '0;
    if (exp_g >= 0) begin
      exp_gv[exp_g] = 1'b1;
      exp_mw   = we_v[exp_g];
      exp_mr   = !we_v[exp_g];
      exp_addr = addr_v[exp_g];
      exp_wd   = wdata_v[exp_g];
    end
  endtask

  // Commit this cycle's effects into the model, then advance past the rising edge.
  task automatic tick();
    int g = exp_g;
    if (reset) begin
      mdl_rv = 2'b00; mdl_rd[0] = '0; mdl_rd[1] = '0;
      mdl_owner = -1; mdl_last = 1; mdl_hold = 0;
    end else begin
      mdl_rv = 2'b00;
      if (g >= 0) begin
        if (!we_v[g]) begin
          mdl_rv[g] = 1'b1;
          mdl_rd[g] = bmem[addr_v[g][11:0]];
        end
        if (lock_v[g]) begin
          if (mdl_owner == g) mdl_hold = (mdl_hold < int'(MAXH)) ? mdl_hold + 1 : mdl_hold;
          else begin mdl_owner = g; mdl_hold = 1; end
        end else begin
          mdl_owner = -1; mdl_hold = 0;
        end
        mdl_last = g;
      end else begin
        mdl_owner = -1; mdl_hold = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) begin settle(); tick(); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00 || {m1_rvalid, m0_rvalid} !== 2'b00 ||
        m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outs: gnt=%b rvalid=%b rdata0=%h rdata1=%h want all zero",
               {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata);
    end
    checks++;
    if (mem_memwrite !== 1'b0 || mem_memread !== 1'b0 || mem_addr !== 32'd0 ||
        mem_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem: we=%b rd=%b addr=%h wd=%h want all zero",
               mem_memwrite, mem_memread, mem_addr, mem_writedata);
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    set_m(0, 1, 1, 32'd2002, 32'h0000BEEF, 0);
    settle();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_memwrite !== 1'b1 || mem_memread !== 1'b0 ||
        mem_addr !== 32'd2002 || mem_writedata !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL sr_write: gnt=%b we=%b rd=%b addr=%0d wd=%h want 01 1 0 2002 0000beef",
               {m1_gnt, m0_gnt}, mem_memwrite, mem_memread, mem_addr, mem_writedata);
    end
    tick();
    set_m(0, 1, 0, 32'd2002, 32'd0, 0);
    settle();
    checks++;
    if (m0_gnt !== 1'b1 || mem_memread !== 1'b1 || mem_memwrite !== 1'b0 || m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL sr_read_gnt: gnt0=%b rd=%b we=%b rvalid0=%b want 1 1 0 0",
               m0_gnt, mem_memread, mem_memwrite, m0_rvalid);
    end
    tick();
    set_m(0, 0, 0, 32'd0, 32'd0, 0);
    settle();
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000BEEF || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL sr_rvalid: rvalid0=%b rdata0=%h rvalid1=%b want 1 0000beef 0",
               m0_rvalid, m0_rdata, m1_rvalid);
    end
    tick();
    settle();
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0000BEEF || mem_memread !== 1'b0) begin
      errors++;
      $display("FAIL sr_hold: rvalid0=%b rdata0=%h rd=%b want 0 0000beef 0",
               m0_rvalid, m0_rdata, mem_memread);
    end
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    set_m(0, 1, 1, 32'd2000, 32'd5, 0);
    set_m(1, 1, 1, 32'd2000, 32'd9, 0);
    settle();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_writedata !== 32'd5) begin
      errors++;
      $display("FAIL tie_first: gnt=%b wd=%0d want 01 5", {m1_gnt, m0_gnt}, mem_writedata);
    end
    tick();
    set_m(0, 0, 0, 32'd0, 32'd0, 0);
    settle();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || mem_writedata !== 32'd9) begin
      errors++;
      $display("FAIL tie_second: gnt=%b wd=%0d want 10 9", {m1_gnt, m0_gnt}, mem_writedata);
    end
    tick();
    set_m(1, 0, 0, 32'd0, 32'd0, 0);
    settle();
    checks++;
    if (bmem[2000] !== 32'd9) begin
      errors++;
      $display("FAIL tie_final: mem[2000]=%0d want 9", bmem[2000]);
    end
    tick();
  endtask

  task automatic test_alternation();
    logic [1:0] want;
    do_reset();
    set_m(0, 1, 0, 32'd2000, 32'd0, 0);
    set_m(1, 1, 0, 32'd2002, 32'd0, 0);
    for (int i = 0; i < 8; i++) begin
      settle();
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt, m0_gnt} !== want ||
          (i > 0 && {m1_rvalid, m0_rvalid} !== ~want)) begin
        errors++;
        $display("FAIL alt_%0d: gnt=%b rvalid=%b want gnt=%b rvalid=%b", i,
                 {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, want, ~want);
      end
      tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_locked_burst();
    int seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [1:0] want;
    do_reset();
    set_m(1, 1, 0, 32'd2004, 32'd0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) set_m(0, 1, 0, 32'd2006, 32'd0, 0);
      settle();
      want = (seq[i] == 1) ? 2'b10 : 2'b01;
      checks++;
      if ({m1_gnt, m0_gnt} !== want) begin
        errors++;
        $display("FAIL burst_%0d: gnt=%b want %b", i, {m1_gnt, m0_gnt}, want);
      end
      tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_lock_no_contention();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i != 11) set_m(0, 1, 1, 32'd2100 + i, i, 1);
      if (i == 10) set_m(1, 1, 0, 32'd2100, 32'd0, 0);
      if (i == 11) set_m(1, 0, 0, 32'd0, 32'd0, 0);
      settle();
      want = (i == 10) ? 2'b10 : 2'b01;
      checks++;
      if ({m1_gnt, m0_gnt} !== want || (i == 11 && m1_rvalid !== 1'b1)) begin
        errors++;
        $display("FAIL nocont_%0d: gnt=%b rvalid1=%b want gnt=%b", i, {m1_gnt, m0_gnt},
                 m1_rvalid, want);
      end
      tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    settle();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_m(0, 1, 0, 32'd2000, 32'd0, 1);
    for (int i = 0; i < 4; i++) begin settle(); tick(); end
    reset = 1'b1;
    settle();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rst_burst_gnt: gnt=%b want 01", {m1_gnt, m0_gnt});
    end
    tick();
    reset = 1'b0;
    set_m(0, 1, 0, 32'd2000, 32'd0, 0);
    set_m(1, 1, 0, 32'd2002, 32'd0, 0);
    settle();
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00 || {m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rst_burst_after: rvalid=%b gnt=%b want 00 01",
               {m1_rvalid, m0_rvalid}, {m1_gnt, m0_gnt});
    end
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    settle();
    tick();
  endtask

  task automatic test_random();
    logic [1:0] granted;
    do_reset();
    granted = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] || granted[i])
          set_m(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                32'd2000 + $urandom_range(0, 7), $urandom, $urandom_range(0, 1) == 1);
      end
      reset = ($urandom_range(0, 49) == 0);
      settle();
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gv || mem_memwrite !== exp_mw || mem_memread !== exp_mr ||
          mem_addr !== exp_addr || mem_writedata !== exp_wd) begin
        errors++;
        $display("FAIL rnd_bus_%0d: gnt=%b we=%b rd=%b addr=%h wd=%h want %b %b %b %h %h", c,
                 {m1_gnt, m0_gnt}, mem_memwrite, mem_memread, mem_addr, mem_writedata,
                 exp_gv, exp_mw, exp_mr, exp_addr, exp_wd);
      end
      checks++;
      if ({m1_rvalid, m0_rvalid} !== mdl_rv || m0_rdata !== mdl_rd[0] ||
          m1_rdata !== mdl_rd[1]) begin
        errors++;
        $display("FAIL rnd_rd_%0d: rvalid=%b rd0=%h rd1=%h want %b %h %h", c,
                 {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, mdl_rv, mdl_rd[0], mdl_rd[1]);
      end
      granted = exp_gv;
      tick();
    end
    reset = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    mdl_owner = -1; mdl_last = 1; mdl_hold = 0;
    mdl_rv = 2'b00; mdl_rd[0] = '0; mdl_rd[1] = '0;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_tie();
    test_alternation();
    test_locked_burst();
    test_lock_no_contention();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
